// File: rtl/br_pred_ctrl_pkg.sv
// Shared types and helpers for the branch direction predictor: counter encodings,
// sweep FSM states and the PC-to-table index mapping.
package br_pred_ctrl_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Instructions are word aligned, so pc[1:0] never selects an entry.
  function automatic logic [31:0] bht_idx(input logic [63:0] pc, input int unsigned depth);
    logic [63:0] mask;
    mask = 64'(depth) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    logic [1:0] nxt;
    nxt = cnt;
    unique case (cnt)
      CNT_SNT: nxt = up ? CNT_WNT : CNT_SNT;
      CNT_WNT: nxt = up ? CNT_WT  : CNT_SNT;
      CNT_WT:  nxt = up ? CNT_ST  : CNT_WNT;
      CNT_ST:  nxt = up ? CNT_ST  : CNT_WT;
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/br_pred_ctrl_if.sv
// Fetch lookup, EX resolve and flush signals between the pipeline and the predictor.
interface br_pred_ctrl_if;
  logic        lk_valid;
  logic [63:0] lk_pc;
  logic        lk_ready;
  logic        lk_taken;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic        ex_taken;
  logic        ex_pr_taken;
  logic        flush;
  logic        q_err;

  modport master (
    output lk_valid, lk_pc, ex_valid, ex_pc, ex_taken, flush,
    input  lk_ready, lk_taken, ex_pr_taken, q_err
  );

  modport slave (
    input  lk_valid, lk_pc, ex_valid, ex_pc, ex_taken, flush,
    output lk_ready, lk_taken, ex_pr_taken, q_err
  );
endinterface

// File: rtl/br_pred_ctrl_pred_fifo.sv
// In-order queue of 1-bit predictions between fetch and EX; flush empties it at once.
module pred_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic empty_o,
  output logic full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign dout_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din_i;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (do_pop) rd_d = rd_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    // Flush wins over any same-cycle push or pop.
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/br_pred_ctrl.sv
// Branch direction predictor: 2-bit counter table with a reset sweep, an in-order
// prediction queue feeding the branch ALU, and training on EX resolution.
module br_pred_ctrl
  import br_pred_ctrl_pkg::*;
#(
  parameter int BHT_DEPTH   = 256,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  br_pred_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [1:0]       bht_q [BHT_DEPTH];
  logic             q_err_q, q_err_d;

  logic             run;
  logic [IDX_W-1:0] lk_idx, ex_idx;
  logic [1:0]       lk_cnt, ex_cnt, ex_cnt_nxt;
  logic             fifo_full, fifo_empty, fifo_dout;
  logic             push, pop, train;

  assign run    = (state_q == ST_RUN);
  assign lk_idx = IDX_W'(bht_idx(bus.lk_pc, BHT_DEPTH));
  assign ex_idx = IDX_W'(bht_idx(bus.ex_pc, BHT_DEPTH));
  assign lk_cnt = bht_q[lk_idx];
  assign ex_cnt = bht_q[ex_idx];
  assign ex_cnt_nxt = sat_step(ex_cnt, bus.ex_taken);

  // Reads see the registered table, so same-cycle training is visible next cycle.
  assign bus.lk_ready    = run && !fifo_full;
  assign bus.lk_taken    = bus.lk_ready ? lk_cnt[1] : 1'b0;
  assign bus.ex_pr_taken = (run && !fifo_empty) ? fifo_dout : 1'b0;
  assign bus.q_err       = q_err_q;

  assign push  = bus.lk_valid && bus.lk_ready;
  assign pop   = run && bus.ex_valid && !fifo_empty;
  assign train = run && bus.ex_valid;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(BHT_DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign q_err_d = q_err_q | (train && fifo_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      q_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      q_err_q <= q_err_d;
    end
  end

  // Sweep and training share the single write port; they never overlap in time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT)
        bht_q[sweep_q] <= CNT_WNT;
      else if (train)
        bht_q[ex_idx] <= ex_cnt_nxt;
    end
  end

  pred_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_pred_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (bus.flush),
    .push_i  (push),
    .din_i   (bus.lk_taken),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_br_pred_ctrl.sv
// Directed and randomized checks of br_pred_ctrl against a queue/array reference model.
module tb_br_pred_ctrl;
  localparam int BD = 256;
  localparam int QD = 4;

  logic clk;
  logic rst;
  br_pred_ctrl_if bus ();

  br_pred_ctrl #(.BHT_DEPTH(BD), .QUEUE_DEPTH(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;
  int init_left;
  int mbht [BD];
  bit mq [$];
  bit mq_err;

  function automatic int idx(input logic [63:0] pc);
    return int'((pc / 64'd4) % 64'(BD));
  endfunction

  function automatic logic [63:0] rpc();
    return (64'($urandom) << 12) | (64'($urandom_range(0, 7)) * 64'd4);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.lk_valid = 0; bus.lk_pc = '0; bus.ex_valid = 0; bus.ex_pc = '0;
    bus.ex_taken = 0; bus.flush = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    init_left = BD;
    mq.delete();
    mq_err = 0;
    for (int i = 0; i < BD; i++) mbht[i] = 1;
    chk("rst_lk_ready", bus.lk_ready, 0);
    chk("rst_ex_pr", bus.ex_pr_taken, 0);
    chk("rst_q_err", bus.q_err, 0);
  endtask

  // One clock: drive, compare combinational outputs, advance model, compare q_err.
  task automatic cyc(input bit lkv, input logic [63:0] lkpc, input bit exv,
                     input logic [63:0] expc, input bit ext, input bit fl);
    bit run, rdy, exp_tk, exp_pr;
    int li, ei;
    bus.lk_valid = lkv; bus.lk_pc = lkpc; bus.ex_valid = exv;
    bus.ex_pc = expc; bus.ex_taken = ext; bus.flush = fl;
    #1;
    run = (init_left == 0);
    rdy = run && (mq.size() < QD);
    li = idx(lkpc);
    ei = idx(expc);
    exp_tk = rdy && (mbht[li] >= 2);
    exp_pr = run && (mq.size() > 0) && mq[0];
    chk("lk_ready", bus.lk_ready, rdy);
    chk("lk_taken", bus.lk_taken, exp_tk);
    chk("ex_pr_taken", bus.ex_pr_taken, exp_pr);
    if (!run) init_left--;
    else begin
      if (exv) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else mq_err = 1;
        if (ext) mbht[ei] = (mbht[ei] == 3) ? 3 : mbht[ei] + 1;
        else     mbht[ei] = (mbht[ei] == 0) ? 0 : mbht[ei] - 1;
      end
      if (lkv && rdy) mq.push_back(exp_tk);
      if (fl) mq.delete();
    end
    @(posedge clk); #1;
    chk("q_err", bus.q_err, mq_err);
  endtask

  task automatic probe(input string tag, input logic [63:0] pc, input bit exp);
    bus.lk_valid = 0; bus.ex_valid = 0; bus.flush = 0; bus.lk_pc = pc;
    #1;
    chk(tag, bus.lk_taken, exp);
  endtask

  task automatic sweep_len(input string tag);
    int n;
    n = 0;
    while (bus.lk_ready !== 1'b1 && n < 400) begin
      cyc(1'($urandom_range(0, 1)), rpc(), 1'($urandom_range(0, 1)), rpc(),
          1'($urandom_range(0, 1)), 0);
      n++;
    end
    chk(tag, n, BD);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_seq [4];
    clk = 0; checks = 0; errors = 0;

    // Reset sweep: ready held low exactly BD cycles, lookups forced 0.
    do_reset();
    probe("init_lk_taken", 64'h1000, 0);
    sweep_len("sweep_len");
    chk("run_ready", bus.lk_ready, 1);

    // Training at 0x1000 and aliasing.
    cyc(1, 64'h1000, 0, 0, 0, 0);
    cyc(1, 64'h1000, 0, 0, 0, 0);
    cyc(0, 0, 1, 64'h1000, 1, 0);
    cyc(0, 0, 1, 64'h1000, 1, 0);
    probe("train_1000", 64'h1000, 1);
    probe("alias_1400", 64'h1400, 1);
    probe("other_1004", 64'h1004, 0);

    // Saturation at 0x20, queue kept non-empty with push+pop.
    cyc(1, 64'h40, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 64'h40, 1, 64'h20, 1, 0);
    cyc(1, 64'h40, 1, 64'h20, 0, 0);
    probe("sat_one_nt", 64'h20, 1);
    cyc(1, 64'h40, 1, 64'h20, 0, 0);
    cyc(1, 64'h40, 1, 64'h20, 0, 0);
    probe("sat_three_nt", 64'h20, 0);
    cyc(0, 0, 1, 64'h300, 0, 0);

    // Backpressure and FIFO order.
    cyc(1, 64'h1000, 0, 0, 0, 0);
    cyc(1, 64'h1004, 0, 0, 0, 0);
    cyc(1, 64'h1400, 0, 0, 0, 0);
    cyc(1, 64'h20, 0, 0, 0, 0);
    chk("bp_full", bus.lk_ready, 0);
    cyc(1, 64'h1000, 0, 0, 0, 0);
    cyc(0, 0, 1, 64'h300, 0, 0);
    chk("bp_cnt3", bus.lk_ready, 1);
    cyc(1, 64'h1004, 1, 64'h300, 0, 0);
    chk("pp_cnt3", bus.lk_ready, 1);
    cyc(1, 64'h1000, 0, 0, 0, 0);
    chk("pp_full", bus.lk_ready, 0);
    exp_seq = '{1, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      chk("fifo_order", bus.ex_pr_taken, exp_seq[i]);
      cyc(0, 0, 1, 64'h300, 0, 0);
    end

    // Flush with same-cycle lookup and training.
    cyc(1, 64'h1000, 0, 0, 0, 0);
    cyc(1, 64'h1000, 0, 0, 0, 0);
    cyc(1, 64'h1000, 1, 64'h1004, 1, 1);
    chk("flush_pr", bus.ex_pr_taken, 0);
    chk("flush_ready", bus.lk_ready, 1);
    probe("flush_train", 64'h1004, 1);

    // Resolve on empty queue: sticky error.
    cyc(0, 0, 1, 64'h2000, 0, 0);
    chk("q_err_set", bus.q_err, 1);
    for (int i = 0; i < 5; i++) cyc(1'($urandom_range(0, 1)), rpc(), 0, 0, 0, 0);
    chk("q_err_sticky", bus.q_err, 1);

    // Reset at sweep index 100 restarts a full sweep.
    do_reset();
    for (int i = 0; i < 100; i++) cyc(0, rpc(), 0, 0, 0, 0);
    do_reset();
    sweep_len("resweep_len");

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++)
      cyc(1'($urandom_range(0, 1)), rpc(), 1'($urandom_range(0, 2) == 0), rpc(),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
